// File: rtl/tc_scan_ctrl_pkg.sv
// Shared definitions for the timer/counter scan sequencer: slot type codes,
// scan FSM encoding, default accumulator width and the per-slot status bundle.
package tc_scan_ctrl_pkg;

    localparam int unsigned TC_ACC_W = 8;

    typedef enum logic [1:0] {
        TC_TYPE_TIMER = 2'b00,
        TC_TYPE_UP    = 2'b01,
        TC_TYPE_DOWN  = 2'b10,
        TC_TYPE_OFF   = 2'b11
    } tc_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10
    } scan_state_e;

    typedef struct packed {
        logic dn;
        logic tt;
        logic cu;
        logic cd;
    } tc_status_t;

endpackage

// File: rtl/tc_scan_ctrl_update_unit.sv
// Shared combinational update datapath: next accumulator and status for one
// timer/counter slot from its stored state and current inputs.
module tc_update_unit
    import tc_scan_ctrl_pkg::*;
#(
    parameter int unsigned ACC_W = TC_ACC_W
) (
    input  tc_type_e         type_i,
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] preset_i,
    input  logic             en_i,
    input  logic             prev_en_i,
    input  logic             rst_i,
    output logic [ACC_W-1:0] acc_o,
    output tc_status_t       stat_o
);

    logic             rise_c;
    logic [ACC_W-1:0] inc_c;
    logic [ACC_W-1:0] up_c;
    logic [ACC_W-1:0] down_c;

    // Counters only move on a rising edge relative to the last scan's sample.
    assign rise_c = en_i & ~prev_en_i;
    assign inc_c  = acc_i + ACC_W'(1);
    assign up_c   = (rise_c && (acc_i != '1)) ? inc_c : acc_i;
    assign down_c = (rise_c && (acc_i != '0)) ? (acc_i - ACC_W'(1)) : acc_i;

    always_comb begin
        acc_o  = acc_i;
        stat_o = '0;
        case (type_i)
            TC_TYPE_TIMER: begin
                if (rst_i || !en_i) begin
                    acc_o = '0;
                end else if (acc_i < preset_i) begin
                    acc_o     = inc_c;
                    stat_o.dn = (inc_c == preset_i);
                    stat_o.tt = (inc_c != preset_i);
                end else begin
                    stat_o.dn = 1'b1;
                end
            end
            TC_TYPE_UP: begin
                stat_o.cu = en_i;
                if (rst_i) begin
                    acc_o = '0;
                end else begin
                    acc_o     = up_c;
                    stat_o.dn = (up_c >= preset_i);
                end
            end
            TC_TYPE_DOWN: begin
                stat_o.cd = en_i;
                if (rst_i) begin
                    acc_o     = preset_i;
                    stat_o.dn = (preset_i == '0);
                end else begin
                    acc_o     = down_c;
                    stat_o.dn = (down_c == '0);
                end
            end
            default: begin
                acc_o = acc_i;
            end
        endcase
    end

endmodule

// File: rtl/tc_scan_ctrl.sv
// Timer/counter bank sequencer: scans every slot through one shared update
// datapath per timebase tick. Define TC_OVERRUN_DET_EN to add the sticky overrun output.
module tc_scan_ctrl
    import tc_scan_ctrl_pkg::*;
#(
    parameter int unsigned TC_NUM = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned ACC_W  = TC_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [1:0]        cfg_type,
    input  logic [ACC_W-1:0]  cfg_preset,
    input  logic [TC_NUM-1:0] en_in,
    input  logic [TC_NUM-1:0] rst_in,
    output logic [TC_NUM-1:0] dn_out,
    output logic [TC_NUM-1:0] tt_out,
    output logic [TC_NUM-1:0] cu_out,
    output logic [TC_NUM-1:0] cd_out,
    output logic              scan_busy,
`ifdef TC_OVERRUN_DET_EN
    output logic              overrun,
`endif
    output logic              scan_done
);

    scan_state_e       state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              pending_q;
    logic              busy_q;
    logic              done_q;

    tc_type_e          type_q   [TC_NUM];
    logic [ACC_W-1:0]  acc_q    [TC_NUM];
    logic [ACC_W-1:0]  preset_q [TC_NUM];
    logic [TC_NUM-1:0] prev_q;
    logic [TC_NUM-1:0] dn_q, tt_q, cu_q, cd_q;

    tc_type_e          rd_type_q;
    logic [ACC_W-1:0]  rd_acc_q;
    logic [ACC_W-1:0]  rd_preset_q;
    logic              rd_prev_q, rd_en_q, rd_rst_q, rd_kill_q;

    logic [ACC_W-1:0]  upd_acc_d;
    tc_status_t        upd_stat_d;
    logic              cfg_ok_c, cfg_hit_c;

    assign cfg_ok_c  = cfg_we && (32'(cfg_addr) < TC_NUM);
    assign cfg_hit_c = cfg_ok_c && (cfg_addr == idx_q);

    tc_update_unit #(.ACC_W(ACC_W)) u_update (
        .type_i    (rd_type_q),
        .acc_i     (rd_acc_q),
        .preset_i  (rd_preset_q),
        .en_i      (rd_en_q),
        .prev_en_i (rd_prev_q),
        .rst_i     (rd_rst_q),
        .acc_o     (upd_acc_d),
        .stat_o    (upd_stat_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            prev_q      <= '0;
            dn_q        <= '0;
            tt_q        <= '0;
            cu_q        <= '0;
            cd_q        <= '0;
            rd_type_q   <= TC_TYPE_OFF;
            rd_acc_q    <= '0;
            rd_preset_q <= '0;
            rd_prev_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_rst_q    <= 1'b0;
            rd_kill_q   <= 1'b0;
            for (int i = 0; i < TC_NUM; i++) begin
                type_q[i]   <= TC_TYPE_OFF;
                acc_q[i]    <= '0;
                preset_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick || pending_q) begin
                        state_q   <= ST_RD;
                        idx_q     <= '0;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_RD: begin
                    pending_q   <= pending_q | tick;
                    rd_type_q   <= type_q[idx_q];
                    rd_acc_q    <= acc_q[idx_q];
                    rd_preset_q <= preset_q[idx_q];
                    rd_prev_q   <= prev_q[idx_q];
                    rd_en_q     <= en_in[idx_q];
                    rd_rst_q    <= rst_in[idx_q];
                    // A config write landing after the read makes the snapshot stale.
                    rd_kill_q   <= cfg_hit_c;
                    state_q     <= ST_WR;
                end
                ST_WR: begin
                    pending_q <= pending_q | tick;
                    if (!(rd_kill_q || cfg_hit_c)) begin
                        acc_q[idx_q]  <= upd_acc_d;
                        dn_q[idx_q]   <= upd_stat_d.dn;
                        tt_q[idx_q]   <= upd_stat_d.tt;
                        cu_q[idx_q]   <= upd_stat_d.cu;
                        cd_q[idx_q]   <= upd_stat_d.cd;
                        prev_q[idx_q] <= rd_en_q;
                    end
                    if (idx_q == ADDR_W'(TC_NUM - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + ADDR_W'(1);
                        state_q <= ST_RD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // Configuration is placed last so it overrides a same-slot scan commit.
            if (cfg_ok_c) begin
                type_q[cfg_addr]   <= tc_type_e'(cfg_type);
                preset_q[cfg_addr] <= cfg_preset;
                acc_q[cfg_addr]    <= (tc_type_e'(cfg_type) == TC_TYPE_DOWN) ? cfg_preset : '0;
                dn_q[cfg_addr]     <= 1'b0;
                tt_q[cfg_addr]     <= 1'b0;
                cu_q[cfg_addr]     <= 1'b0;
                cd_q[cfg_addr]     <= 1'b0;
                prev_q[cfg_addr]   <= en_in[cfg_addr];
            end
        end
    end

`ifdef TC_OVERRUN_DET_EN
    logic overrun_q;

    // A tick arriving while one is already queued means a scan period was lost.
    always_ff @(posedge clk) begin
        if (reset || cfg_we) begin
            overrun_q <= 1'b0;
        end else if (tick && pending_q) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

    assign dn_out    = dn_q;
    assign tt_out    = tt_q;
    assign cu_out    = cu_q;
    assign cd_out    = cd_q;
    assign scan_busy = busy_q;
    assign scan_done = done_q;

endmodule

// File: tb/tb_tc_scan_ctrl.sv
// Self-checking bench for tc_scan_ctrl: directed scenarios plus randomized scans
// against a per-slot behavioural model. Honours TC_OVERRUN_DET_EN when defined.
module tb_tc_scan_ctrl;

    localparam int unsigned NUM  = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned W    = 8;
    localparam int          MAXV = 255;

    logic           clk;
    logic           reset;
    logic           tick;
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [1:0]     cfg_type;
    logic [W-1:0]   cfg_preset;
    logic [NUM-1:0] en_in;
    logic [NUM-1:0] rst_in;
    logic [NUM-1:0] dn_out, tt_out, cu_out, cd_out;
    logic           scan_busy, scan_done;
`ifdef TC_OVERRUN_DET_EN
    logic           overrun;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state, one entry per slot.
    int             m_acc    [NUM];
    int             m_preset [NUM];
    int             m_type   [NUM];
    logic [NUM-1:0] m_prev, m_dn, m_tt, m_cu, m_cd;

    tc_scan_ctrl #(.TC_NUM(NUM), .ADDR_W(AW), .ACC_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_type   (cfg_type),
        .cfg_preset (cfg_preset),
        .en_in      (en_in),
        .rst_in     (rst_in),
        .dn_out     (dn_out),
        .tt_out     (tt_out),
        .cu_out     (cu_out),
        .cd_out     (cd_out),
        .scan_busy  (scan_busy),
`ifdef TC_OVERRUN_DET_EN
        .overrun    (overrun),
`endif
        .scan_done  (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NUM; s++) begin
            m_acc[s]    = 0;
            m_preset[s] = 0;
            m_type[s]   = 3;
        end
        m_prev = '0; m_dn = '0; m_tt = '0; m_cu = '0; m_cd = '0;
    endfunction

    function automatic void model_cfg(input int a, input int t, input int p);
        m_type[a]   = t;
        m_preset[a] = p;
        m_acc[a]    = (t == 2) ? p : 0;
        m_dn[a] = 1'b0; m_tt[a] = 1'b0; m_cu[a] = 1'b0; m_cd[a] = 1'b0;
        m_prev[a]   = en_in[a];
    endfunction

    // One full scan: every slot evaluated from the rules with the current inputs.
    function automatic void model_scan();
        for (int s = 0; s < NUM; s++) begin
            bit en, rs, rise;
            en   = en_in[s];
            rs   = rst_in[s];
            rise = en && !m_prev[s];
            m_dn[s] = 1'b0; m_tt[s] = 1'b0; m_cu[s] = 1'b0; m_cd[s] = 1'b0;
            if (m_type[s] == 0) begin
                if (rs || !en) m_acc[s] = 0;
                else if (m_acc[s] < m_preset[s]) begin
                    m_acc[s] = m_acc[s] + 1;
                    if (m_acc[s] == m_preset[s]) m_dn[s] = 1'b1;
                    else m_tt[s] = 1'b1;
                end else m_dn[s] = 1'b1;
            end else if (m_type[s] == 1) begin
                m_cu[s] = en;
                if (rs) m_acc[s] = 0;
                else begin
                    if (rise && m_acc[s] < MAXV) m_acc[s] = m_acc[s] + 1;
                    m_dn[s] = (m_acc[s] >= m_preset[s]);
                end
            end else if (m_type[s] == 2) begin
                m_cd[s] = en;
                if (rs) begin
                    m_acc[s] = m_preset[s];
                    m_dn[s]  = (m_preset[s] == 0);
                end else begin
                    if (rise && m_acc[s] > 0) m_acc[s] = m_acc[s] - 1;
                    m_dn[s] = (m_acc[s] == 0);
                end
            end
            m_prev[s] = en;
        end
    endfunction

    task automatic check_status(input string tag);
        check({tag, " dn"}, 32'(dn_out), 32'(m_dn));
        check({tag, " tt"}, 32'(tt_out), 32'(m_tt));
        check({tag, " cu"}, 32'(cu_out), 32'(m_cu));
        check({tag, " cd"}, 32'(cd_out), 32'(m_cd));
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        do begin
            step();
            c++;
        end while (!scan_done && c < 60);
        check({tag, " scan_done"}, 32'(scan_done), 32'd1);
    endtask

    task automatic cfg(input int a, input int t, input int p);
        cfg_we     = 1'b1;
        cfg_addr   = AW'(a);
        cfg_type   = 2'(t);
        cfg_preset = W'(p);
        model_cfg(a, t, p);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run_scan(input string tag);
        tick = 1'b1;
        step();
        tick = 1'b0;
        wait_done(tag);
        model_scan();
        check_status(tag);
        repeat (2) step();
    endtask

    initial begin
        bit seen_busy;
        reset = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_type = '0;
        cfg_preset = '0; en_in = '0; rst_in = '0;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        check("reset dn", 32'(dn_out), 32'd0);
        check("reset busy", 32'(scan_busy), 32'd0);
        check("reset done", 32'(scan_done), 32'd0);
        check_status("reset");

        // On-delay timer
        en_in[2] = 1'b1;
        cfg(2, 0, 3);
        run_scan("tmr1"); check("tmr1 tt2", 32'(tt_out[2]), 32'd1); repeat (20) step();
        run_scan("tmr2"); check("tmr2 tt2", 32'(tt_out[2]), 32'd1); repeat (20) step();
        run_scan("tmr3"); check("tmr3 dn2", 32'(dn_out[2]), 32'd1);
        check("tmr3 tt2", 32'(tt_out[2]), 32'd0);
        en_in[2] = 1'b0;
        run_scan("tmr_off"); check("tmr_off dn2", 32'(dn_out[2]), 32'd0);
        en_in[5] = 1'b1;
        cfg(5, 0, 0);
        run_scan("tmr_p0"); check("tmr_p0 dn5", 32'(dn_out[5]), 32'd1);

        // Up counter
        cfg(0, 1, 2);
        en_in[0] = 1'b1; run_scan("up_e1");
        en_in[0] = 1'b0; run_scan("up_l1");
        en_in[0] = 1'b1; run_scan("up_e2");
        check("up dn0", 32'(dn_out[0]), 32'd1);
        en_in[0] = 1'b0;
        cfg(0, 1, 255);
        for (int i = 0; i < 257; i++) begin
            en_in[0] = 1'b1; run_scan($sformatf("sat_h%0d", i));
            en_in[0] = 1'b0; run_scan($sformatf("sat_l%0d", i));
        end
        check("sat acc", 32'(m_acc[0]), 32'd255);
        check("sat dn0", 32'(dn_out[0]), 32'd1);
        rst_in[0] = 1'b1; run_scan("up_rst");
        check("up_rst dn0", 32'(dn_out[0]), 32'd0);
        rst_in[0] = 1'b0;

        // Down counter
        cfg(7, 2, 2);
        rst_in[7] = 1'b1; run_scan("dn_rst");
        rst_in[7] = 1'b0;
        en_in[7] = 1'b1; run_scan("dn_e1");
        en_in[7] = 1'b0; run_scan("dn_l1");
        en_in[7] = 1'b1; run_scan("dn_e2");
        check("dn dn7", 32'(dn_out[7]), 32'd1);
        check("dn cd7", 32'(cd_out[7]), 32'd1);
        en_in[7] = 1'b0; run_scan("dn_l2");
        check("dn cd7 low", 32'(cd_out[7]), 32'd0);
        en_in[7] = 1'b1; run_scan("dn_e3");
        check("dn hold0", 32'(dn_out[7]), 32'd1);

        // Scan timing and pending tick
        tick = 1'b1;
        step();
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) step();
            tick = (k == 5);
            check($sformatf("tim busy k%0d", k), 32'(scan_busy), 32'((k <= 16) || (k == 18)));
            check($sformatf("tim done k%0d", k), 32'(scan_done), 32'(k == 17));
            if (k == 17) begin
                model_scan();
                check_status("tim scan1");
            end
        end
        tick = 1'b0;
        wait_done("tim2");
        model_scan();
        check_status("tim scan2");
        repeat (2) step();

        // Config write during WR of slot 3 wins over the scan result
        en_in[3] = 1'b0;
        cfg(3, 1, 0);
        en_in[3] = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 2; k <= 8; k++) step();
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_type = 2'd0; cfg_preset = 8'd5;
        step();
        cfg_we = 1'b0;
        wait_done("cfgwr");
        model_scan();
        model_cfg(3, 0, 5);
        check_status("cfgwr");
        check("cfgwr cu3", 32'(cu_out[3]), 32'd0);
        check("cfgwr dn3", 32'(dn_out[3]), 32'd0);
        repeat (2) step();
        run_scan("cfgwr_next");

        // Reset in the middle of a scan
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 2; k <= 9; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        check("mid_rst busy", 32'(scan_busy), 32'd0);
        check("mid_rst done", 32'(scan_done), 32'd0);
        check_status("mid_rst");
`ifdef TC_OVERRUN_DET_EN
        check("mid_rst overrun", 32'(overrun), 32'd0);
`endif

        // Three ticks in one scan collapse to a single follow-up scan
        en_in[1] = 1'b1;
        cfg(1, 0, 4);
        tick = 1'b1;
        step();
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) step();
            tick = (k == 3) || (k == 5);
        end
        check("ovr done1", 32'(scan_done), 32'd1);
        model_scan();
        wait_done("ovr2");
        model_scan();
        check_status("ovr");
        seen_busy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            seen_busy = seen_busy | scan_busy;
        end
        check("collapse", 32'(seen_busy), 32'd0);
`ifdef TC_OVERRUN_DET_EN
        check("overrun set", 32'(overrun), 32'd1);
        cfg(6, 3, 0);
        check("overrun clr", 32'(overrun), 32'd0);
`endif

        // Randomized scans
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 3)
                cfg($urandom_range(0, NUM - 1), $urandom_range(0, 3), $urandom_range(0, 4));
            en_in  = NUM'($urandom);
            rst_in = NUM'($urandom) & NUM'($urandom) & NUM'($urandom);
            run_scan($sformatf("rnd%0d", it));
            repeat ($urandom_range(0, 5)) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
